// File: rtl/latch_bank_pkg.sv
// Shared constants and helpers for the latch_bank holding-register array.
// Parity output is enabled by defining LATCH_BANK_PARITY_EN.
package latch_bank_pkg;

    localparam int WIDTH_DEF       = 8;
    localparam int CHANNELS_DEF    = 4;
    localparam int HOLD_CYCLES_DEF = 0;

    // Hold-off counter width; a zero hold still keeps a 1-bit counter.
    function automatic int cnt_width(input int hold);
        return (hold < 1) ? 1 : $clog2(hold + 1);
    endfunction

    typedef logic [cnt_width(HOLD_CYCLES_DEF)-1:0] hold_cnt_t;

endpackage

// File: rtl/latch_bank_chan.sv
// One holding channel: held value, sticky changed flag, post-load hold-off counter.
// Optional parity bit when LATCH_BANK_PARITY_EN is defined.
module latch_bank_chan
    import latch_bank_pkg::*;
#(
    parameter int WIDTH       = WIDTH_DEF,
    parameter int HOLD_CYCLES = HOLD_CYCLES_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             en,
    input  logic [WIDTH-1:0] data,
    input  logic             ack,
    output logic [WIDTH-1:0] q,
    output logic             changed,
    output logic             locked
`ifdef LATCH_BANK_PARITY_EN
    ,
    output logic             q_par
`endif
);

    localparam int CW = cnt_width(HOLD_CYCLES);
    localparam logic [CW-1:0] HOLD_VAL = CW'(HOLD_CYCLES);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    logic [CW-1:0] cnt;
    logic          load;

    assign load   = en && (cnt == '0);
    assign locked = (cnt != '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q       <= '0;
            changed <= 1'b0;
            cnt     <= '0;
        end else if (clear) begin
            q       <= '0;
            changed <= 1'b0;
            cnt     <= '0;
        end else begin
            if (load) begin
                q   <= data;
                cnt <= HOLD_VAL;
            end else if (cnt != '0) begin
                cnt <= cnt - CNT_ONE;
            end
            // A differing load on the same edge as ack keeps the flag set.
            if (load && (data != q))
                changed <= 1'b1;
            else if (ack)
                changed <= 1'b0;
        end
    end

`ifdef LATCH_BANK_PARITY_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            q_par <= 1'b0;
        else if (clear)
            q_par <= 1'b0;
        else if (load)
            q_par <= ^data;
    end
`endif

endmodule

// File: rtl/latch_bank.sv
// Array of CHANNELS independent holding registers with change flags and hold-off.
// Defining LATCH_BANK_PARITY_EN adds the per-channel q_par output.
module latch_bank
    import latch_bank_pkg::*;
#(
    parameter int WIDTH       = WIDTH_DEF,
    parameter int CHANNELS    = CHANNELS_DEF,
    parameter int HOLD_CYCLES = HOLD_CYCLES_DEF
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      clear,
    input  logic [CHANNELS-1:0]       en,
    input  logic [CHANNELS*WIDTH-1:0] data,
    input  logic [CHANNELS-1:0]       ack,
    output logic [CHANNELS*WIDTH-1:0] q,
    output logic [CHANNELS-1:0]       changed,
    output logic [CHANNELS-1:0]       locked
`ifdef LATCH_BANK_PARITY_EN
    ,
    output logic [CHANNELS-1:0]       q_par
`endif
);

    for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
        latch_bank_chan #(
            .WIDTH       (WIDTH),
            .HOLD_CYCLES (HOLD_CYCLES)
        ) u_chan (
            .clk     (clk),
            .reset   (reset),
            .clear   (clear),
            .en      (en[c]),
            .data    (data[c*WIDTH +: WIDTH]),
            .ack     (ack[c]),
            .q       (q[c*WIDTH +: WIDTH]),
            .changed (changed[c]),
            .locked  (locked[c])
`ifdef LATCH_BANK_PARITY_EN
            ,
            .q_par   (q_par[c])
`endif
        );
    end

endmodule

// File: tb/tb_latch_bank.sv
// Directed bench for latch_bank: one instance without hold-off, one with HOLD_CYCLES=3.
// Parity checks are compiled in when LATCH_BANK_PARITY_EN is defined.
module tb_latch_bank;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        clear = 1'b0;
    logic [3:0]  en0 = '0, ack0 = '0, en3 = '0, ack3 = '0;
    logic [31:0] data0 = '0, data3 = '0;
    logic [31:0] q0, q3;
    logic [3:0]  changed0, locked0, changed3, locked3;
`ifdef LATCH_BANK_PARITY_EN
    logic [3:0]  q_par0, q_par3;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    latch_bank u_dut0 (
        .clk (clk), .reset (reset), .clear (clear),
        .en (en0), .data (data0), .ack (ack0),
        .q (q0), .changed (changed0), .locked (locked0)
`ifdef LATCH_BANK_PARITY_EN
        , .q_par (q_par0)
`endif
    );

    latch_bank #(.HOLD_CYCLES(3)) u_dut3 (
        .clk (clk), .reset (reset), .clear (clear),
        .en (en3), .data (data3), .ack (ack3),
        .q (q3), .changed (changed3), .locked (locked3)
`ifdef LATCH_BANK_PARITY_EN
        , .q_par (q_par3)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        tick();
        tick();
        checks++;
        if (q0 !== 32'h0 || changed0 !== 4'h0 || locked0 !== 4'h0) begin
            errors++;
            $display("FAIL reset_init: q=%h changed=%b locked=%b, required 0/0/0", q0, changed0, locked0);
        end
        reset = 1'b0;
        tick();
        // Load 0xA5 into ch0 of both instances, then reset asynchronously mid-cycle.
        en0 = 4'b0001; data0 = 32'h0000_00A5;
        en3 = 4'b0001; data3 = 32'h0000_00A5;
        tick();
        en0 = '0; en3 = '0;
        checks++;
        if (q0[7:0] !== 8'hA5 || changed0[0] !== 1'b1 || locked3[0] !== 1'b1) begin
            errors++;
            $display("FAIL reset_preload: q0=%h changed0=%b locked3=%b, required a5/1/1", q0[7:0], changed0[0], locked3[0]);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if (q0 !== 32'h0 || changed0 !== 4'h0 || locked0 !== 4'h0) begin
            errors++;
            $display("FAIL reset_async_dut0: q=%h changed=%b locked=%b, required 0/0/0", q0, changed0, locked0);
        end
        checks++;
        if (q3 !== 32'h0 || changed3 !== 4'h0 || locked3 !== 4'h0) begin
            errors++;
            $display("FAIL reset_async_dut3: q=%h changed=%b locked=%b, required 0/0/0", q3, changed3, locked3);
        end
        #1 reset = 1'b0;
        tick();
    endtask

    task automatic test_load_change();
        en0 = 4'b0001; data0 = 32'h0000_003C;
        tick();
        en0 = '0;
        checks++;
        if (q0[7:0] !== 8'h3C || changed0 !== 4'b0001 || locked0 !== 4'h0) begin
            errors++;
            $display("FAIL load_first: q0=%h changed=%b locked=%b, required 3c/0001/0000", q0[7:0], changed0, locked0);
        end
        ack0 = 4'b0001;
        tick();
        ack0 = '0;
        checks++;
        if (changed0[0] !== 1'b0) begin
            errors++;
            $display("FAIL ack_clear: changed0=%b, required 0", changed0[0]);
        end
        en0 = 4'b0001; data0 = 32'h0000_003C;
        tick();
        en0 = '0;
        checks++;
        if (q0[7:0] !== 8'h3C || changed0[0] !== 1'b0) begin
            errors++;
            $display("FAIL reload_same: q0=%h changed0=%b, required 3c/0", q0[7:0], changed0[0]);
        end
    endtask

    task automatic test_lockout();
        logic [7:0] exp_q   [5] = '{8'h11, 8'h11, 8'h11, 8'h11, 8'h22};
        logic       exp_lck [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        en3 = 4'b0001; data3 = 32'h0000_0011;
        tick();
        data3 = 32'h0000_0022;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (q3[7:0] !== exp_q[i] || locked3[0] !== exp_lck[i]) begin
                errors++;
                $display("FAIL lockout_t%0d: q3=%h locked=%b, required %h/%b", i, q3[7:0], locked3[0], exp_q[i], exp_lck[i]);
            end
            if (i < 4) tick();
        end
        en3 = '0;
    endtask

    task automatic test_ack_collision();
        en0 = 4'b0010; data0 = 32'h0000_5500;
        tick();
        en0 = '0;
        checks++;
        if (changed0[1] !== 1'b1 || q0[15:8] !== 8'h55) begin
            errors++;
            $display("FAIL collision_setup: changed1=%b q1=%h, required 1/55", changed0[1], q0[15:8]);
        end
        en0 = 4'b0010; ack0 = 4'b0010; data0 = 32'h0000_6600;
        tick();
        en0 = '0; ack0 = '0;
        checks++;
        if (changed0[1] !== 1'b1 || q0[15:8] !== 8'h66) begin
            errors++;
            $display("FAIL collision_set_wins: changed1=%b q1=%h, required 1/66", changed0[1], q0[15:8]);
        end
        ack0 = 4'b0010;
        tick();
        ack0 = '0;
        checks++;
        if (changed0[1] !== 1'b0) begin
            errors++;
            $display("FAIL collision_ack_after: changed1=%b, required 0", changed0[1]);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] vals [3] = '{8'h01, 8'h02, 8'h03};
        en0 = 4'b0001;
        for (int i = 0; i < 3; i++) begin
            data0 = {24'h0, vals[i]};
            tick();
            checks++;
            if (q0[7:0] !== vals[i] || locked0[0] !== 1'b0) begin
                errors++;
                $display("FAIL back_to_back_%0d: q0=%h locked=%b, required %h/0", i, q0[7:0], locked0[0], vals[i]);
            end
        end
        en0 = '0;
    endtask

    task automatic test_independence();
        en0 = 4'b1100; data0 = 32'h0307_FFFF;
        tick();
        en0 = '0;
        checks++;
        if (q0 !== 32'h0307_6603) begin
            errors++;
            $display("FAIL independence: q=%h, required 03076603", q0);
        end
`ifdef LATCH_BANK_PARITY_EN
        checks++;
        if (q_par0 !== 4'b0100) begin
            errors++;
            $display("FAIL parity: q_par=%b, required 0100", q_par0);
        end
`endif
    endtask

    task automatic test_clear();
        clear = 1'b1;
        en0 = 4'hF; data0 = 32'hFFFF_FFFF;
        en3 = 4'hF; data3 = 32'hFFFF_FFFF;
        tick();
        clear = 1'b0; en0 = '0; en3 = '0;
        checks++;
        if (q0 !== 32'h0 || changed0 !== 4'h0 || locked0 !== 4'h0) begin
            errors++;
            $display("FAIL clear_dut0: q=%h changed=%b locked=%b, required 0/0/0", q0, changed0, locked0);
        end
        checks++;
        if (q3 !== 32'h0 || changed3 !== 4'h0 || locked3 !== 4'h0) begin
            errors++;
            $display("FAIL clear_dut3: q=%h changed=%b locked=%b, required 0/0/0", q3, changed3, locked3);
        end
`ifdef LATCH_BANK_PARITY_EN
        checks++;
        if (q_par0 !== 4'h0) begin
            errors++;
            $display("FAIL clear_parity: q_par=%b, required 0000", q_par0);
        end
`endif
        ack0 = 4'hF;
        en3 = 4'b0001; data3 = 32'h0000_0044;
        tick();
        ack0 = '0; en3 = '0;
        checks++;
        if (changed0 !== 4'h0) begin
            errors++;
            $display("FAIL ack_noop: changed=%b, required 0000", changed0);
        end
        checks++;
        if (q3[7:0] !== 8'h44 || locked3[0] !== 1'b1 || changed3[0] !== 1'b1) begin
            errors++;
            $display("FAIL load_after_clear: q3=%h locked=%b changed=%b, required 44/1/1", q3[7:0], locked3[0], changed3[0]);
        end
    endtask

    initial begin
        test_reset();
        test_load_change();
        test_lockout();
        test_ack_collision();
        test_back_to_back();
        test_independence();
        test_clear();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
